// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared widths and the per-register state layout for the renaming
//   architectural register file (regfile_rn) and its read-port sub-module.
package regfile_pkg;

    localparam int XLEN           = 32;  // data width
    localparam int REG_ADDR_WIDTH = 5;   // 2**REG_ADDR_WIDTH registers
    localparam int Q_WIDTH        = 4;   // ROB tag width
    localparam int NUM_RD         = 2;   // (rs1, rs2) read-port pairs

    // Architectural state held for each register in the default
    // configuration. The top keeps these fields as separate packed arrays
    // so the widths can follow the module parameters.
    typedef struct packed {
        logic [XLEN-1:0]    value;
        logic [Q_WIDTH-1:0] tag;
        logic               busy;
    } reg_state_t;

endpackage

// File: rtl/regfile_rn_rdport.sv
// regfile_rn_rdport
//   One combinational read port of the register file. It selects the
//   addressed register's value/tag/busy and forwards a retiring value when
//   the commit in flight is the one the register is waiting on.
// Ports:
//   i_rs                 source register address
//   i_value/i_tag/i_busy whole register-file state (x0 entry is always 0)
//   i_commit_*           commit bus of the current cycle
//   o_v/o_q/o_busy       operand value, producing tag, not-yet-available
module regfile_rn_rdport
    import regfile_pkg::*;
#(
    parameter int P_XLEN = XLEN,
    parameter int P_RAW  = REG_ADDR_WIDTH,
    parameter int P_QW   = Q_WIDTH,
    parameter int P_NREG = 2 ** P_RAW
) (
    input  logic [P_RAW-1:0]              i_rs,
    input  logic [P_NREG-1:0][P_XLEN-1:0] i_value,
    input  logic [P_NREG-1:0][P_QW-1:0]   i_tag,
    input  logic [P_NREG-1:0]             i_busy,
    input  logic                          i_commit_valid,
    input  logic [P_RAW-1:0]              i_commit_rd,
    input  logic [P_QW-1:0]               i_commit_q,
    input  logic [P_XLEN-1:0]             i_commit_v,
    output logic [P_XLEN-1:0]             o_v,
    output logic [P_QW-1:0]               o_q,
    output logic                          o_busy
);

    logic w_hit;

    // Bypass only when the commit is the producer this register waits on;
    // a stale commit (older tag) must not mark a newer rename ready.
    assign w_hit = i_commit_valid
                && (i_commit_rd == i_rs)
                && (i_rs != '0)
                && i_busy[i_rs]
                && (i_tag[i_rs] == i_commit_q);

    assign o_v    = w_hit ? i_commit_v : i_value[i_rs];
    assign o_q    = i_tag[i_rs];
    assign o_busy = i_busy[i_rs] & ~w_hit;

endmodule

// File: rtl/regfile_rn.sv
// regfile_rn
//   Architectural register file with ROB rename tags for the Tomasulo core.
//   Issue claims a destination (tag + busy), ROB commit writes the value and
//   retires the rename if the tags match, flush drops all renames.
// Ports:
//   clk_in, rst_in (sync, active low), rdy_in (low = hold state)
//   rs1/rs2       packed source addresses, pair k in slice k
//   issue_*       destination claim pulse
//   commit_*      ROB retire pulse
//   flush_in      misprediction recovery
//   v1/v2, q1/q2, busy1/busy2  combinational operand outputs per pair
//   busy_cnt      registered count of busy registers
module regfile_rn
    import regfile_pkg::*;
#(
    parameter int XLEN           = regfile_pkg::XLEN,
    parameter int REG_ADDR_WIDTH = regfile_pkg::REG_ADDR_WIDTH,
    parameter int Q_WIDTH        = regfile_pkg::Q_WIDTH,
    parameter int NUM_RD         = regfile_pkg::NUM_RD
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic                             rdy_in,
    input  logic [NUM_RD*REG_ADDR_WIDTH-1:0] rs1,
    input  logic [NUM_RD*REG_ADDR_WIDTH-1:0] rs2,
    input  logic                             issue_valid,
    input  logic [REG_ADDR_WIDTH-1:0]        issue_rd,
    input  logic [Q_WIDTH-1:0]               issue_q,
    input  logic                             commit_valid,
    input  logic [REG_ADDR_WIDTH-1:0]        commit_rd,
    input  logic [Q_WIDTH-1:0]               commit_q,
    input  logic [XLEN-1:0]                  commit_v,
    input  logic                             flush_in,
    output logic [NUM_RD*XLEN-1:0]           v1,
    output logic [NUM_RD*XLEN-1:0]           v2,
    output logic [NUM_RD*Q_WIDTH-1:0]        q1,
    output logic [NUM_RD*Q_WIDTH-1:0]        q2,
    output logic [NUM_RD-1:0]                busy1,
    output logic [NUM_RD-1:0]                busy2,
    output logic [REG_ADDR_WIDTH:0]          busy_cnt
);

    localparam int NREG = 2 ** REG_ADDR_WIDTH;
    localparam int CW   = REG_ADDR_WIDTH + 1;
    localparam int NP   = 2 * NUM_RD;

    logic [NREG-1:0][XLEN-1:0]    r_value;
    logic [NREG-1:0][Q_WIDTH-1:0] r_tag;
    logic [NREG-1:0]              r_busy;
    logic [CW-1:0]                r_busy_cnt;

    logic [NREG-1:0][XLEN-1:0]    w_value_nxt;
    logic [NREG-1:0][Q_WIDTH-1:0] w_tag_nxt;
    logic [NREG-1:0]              w_busy_nxt;
    logic [CW-1:0]                w_cnt_nxt;

    // ---------------- next-state ----------------
    always_comb begin
        w_value_nxt = r_value;
        w_tag_nxt   = r_tag;
        w_busy_nxt  = r_busy;
        w_cnt_nxt   = r_busy_cnt;
        if (rdy_in) begin
            for (int i = 1; i < NREG; i++) begin
                // Commit first: value always lands, busy only retires when
                // the tag is still the one being committed.
                if (commit_valid && commit_rd == REG_ADDR_WIDTH'(i)) begin
                    w_value_nxt[i] = commit_v;
                    if (r_busy[i] && r_tag[i] == commit_q)
                        w_busy_nxt[i] = 1'b0;
                end
                // Flush wins over issue; issue wins over a same-cycle
                // commit for tag/busy so the newer rename survives.
                if (flush_in) begin
                    w_busy_nxt[i] = 1'b0;
                end else if (issue_valid && issue_rd == REG_ADDR_WIDTH'(i)) begin
                    w_tag_nxt[i]  = issue_q;
                    w_busy_nxt[i] = 1'b1;
                end
            end
        end
        // x0 is hardwired.
        w_value_nxt[0] = '0;
        w_tag_nxt[0]   = '0;
        w_busy_nxt[0]  = 1'b0;
        // Count edges of the busy vector rather than repopulating, so an
        // issue+commit on an already-busy register nets to zero.
        for (int i = 0; i < NREG; i++) begin
            if (w_busy_nxt[i] && !r_busy[i])
                w_cnt_nxt = w_cnt_nxt + CW'(1);
            else if (!w_busy_nxt[i] && r_busy[i])
                w_cnt_nxt = w_cnt_nxt - CW'(1);
        end
    end

    // ---------------- state ----------------
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_value    <= '0;
            r_tag      <= '0;
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            r_value    <= w_value_nxt;
            r_tag      <= w_tag_nxt;
            r_busy     <= w_busy_nxt;
            r_busy_cnt <= w_cnt_nxt;
        end
    end

    assign busy_cnt = r_busy_cnt;

    // ---------------- read ports ----------------
    // Ports 0..NUM_RD-1 serve rs1 pairs, NUM_RD..NP-1 serve rs2 pairs.
    logic [NP-1:0][REG_ADDR_WIDTH-1:0] w_rs;
    logic [NP-1:0][XLEN-1:0]           w_v;
    logic [NP-1:0][Q_WIDTH-1:0]        w_q;
    logic [NP-1:0]                     w_busy;

    assign w_rs = {rs2, rs1};

    for (genvar k = 0; k < NP; k++) begin : g_rdport
        regfile_rn_rdport #(
            .P_XLEN (XLEN),
            .P_RAW  (REG_ADDR_WIDTH),
            .P_QW   (Q_WIDTH),
            .P_NREG (NREG)
        ) u_rdport (
            .i_rs           (w_rs[k]),
            .i_value        (r_value),
            .i_tag          (r_tag),
            .i_busy         (r_busy),
            .i_commit_valid (commit_valid),
            .i_commit_rd    (commit_rd),
            .i_commit_q     (commit_q),
            .i_commit_v     (commit_v),
            .o_v            (w_v[k]),
            .o_q            (w_q[k]),
            .o_busy         (w_busy[k])
        );
    end

    assign v1    = w_v[NUM_RD-1:0];
    assign v2    = w_v[NP-1:NUM_RD];
    assign q1    = w_q[NUM_RD-1:0];
    assign q2    = w_q[NP-1:NUM_RD];
    assign busy1 = w_busy[NUM_RD-1:0];
    assign busy2 = w_busy[NP-1:NUM_RD];

endmodule

// File: tb/tb_regfile_rn.sv
// Directed bench for regfile_rn (default parameters, NUM_RD = 2).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_regfile_rn;
    import regfile_pkg::*;

    localparam int RAW = REG_ADDR_WIDTH;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    rdy;
    logic [2*RAW-1:0]        rs1, rs2;
    logic                    issue_valid;
    logic [RAW-1:0]          issue_rd;
    logic [Q_WIDTH-1:0]      issue_q;
    logic                    commit_valid;
    logic [RAW-1:0]          commit_rd;
    logic [Q_WIDTH-1:0]      commit_q;
    logic [XLEN-1:0]         commit_v;
    logic                    flush;
    logic [2*XLEN-1:0]       v1, v2;
    logic [2*Q_WIDTH-1:0]    q1, q2;
    logic [1:0]              busy1, busy2;
    logic [RAW:0]            busy_cnt;

    int checks = 0;
    int errors = 0;

    regfile_rn dut (
        .clk_in       (clk),
        .rst_in       (rst_n),
        .rdy_in       (rdy),
        .rs1          (rs1),
        .rs2          (rs2),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_q      (issue_q),
        .commit_valid (commit_valid),
        .commit_rd    (commit_rd),
        .commit_q     (commit_q),
        .commit_v     (commit_v),
        .flush_in     (flush),
        .v1           (v1),
        .v2           (v2),
        .q1           (q1),
        .q2           (q2),
        .busy1        (busy1),
        .busy2        (busy2),
        .busy_cnt     (busy_cnt)
    );

    always #5 clk = ~clk;

    // Stimulus helpers (drive only).
    task automatic idle();
        issue_valid = 0; issue_rd = '0; issue_q = '0;
        commit_valid = 0; commit_rd = '0; commit_q = '0; commit_v = '0;
        flush = 0; rdy = 1;
    endtask

    task automatic read_all(input logic [RAW-1:0] r);
        rs1 = {r, r};
        rs2 = {r, r};
    endtask

    task automatic do_issue(input logic [RAW-1:0] rd, input logic [Q_WIDTH-1:0] q);
        issue_valid = 1; issue_rd = rd; issue_q = q;
    endtask

    task automatic do_commit(input logic [RAW-1:0] rd, input logic [Q_WIDTH-1:0] q,
                             input logic [XLEN-1:0] v);
        commit_valid = 1; commit_rd = rd; commit_q = q; commit_v = v;
    endtask

    // Consume current inputs at the rising edge, return to the falling edge.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        idle();
        #1;
    endtask

    task automatic test_reset();
        idle(); rst_n = 0; read_all(5'd5);
        @(negedge clk); cycle(); cycle();
        rst_n = 1; #1;
        checks++;
        if ({v1, v2} !== '0) begin
            errors++; $display("FAIL reset_v got %h expected 0", {v1, v2});
        end
        checks++;
        if ({busy1, busy2, q1, q2} !== '0) begin
            errors++; $display("FAIL reset_busy_q got %h expected 0", {busy1, busy2, q1, q2});
        end
        checks++;
        if (busy_cnt !== 6'd0) begin
            errors++; $display("FAIL reset_cnt got %0d expected 0", busy_cnt);
        end
    endtask

    task automatic test_tag0();
        do_issue(5'd3, 4'd0); cycle();
        read_all(5'd3); #1;
        checks++;
        if ({busy1, busy2} !== 4'b1111 || {q1, q2} !== '0) begin
            errors++; $display("FAIL tag0_busy got busy=%b q=%h expected 1111 q=0", {busy1, busy2}, {q1, q2});
        end
        checks++;
        if (busy_cnt !== 6'd1) begin
            errors++; $display("FAIL tag0_cnt got %0d expected 1", busy_cnt);
        end
        do_commit(5'd3, 4'd0, 32'hDEADBEEF); #1;
        checks++;
        if ({busy1, busy2} !== 4'b0000 || v1 !== {2{32'hDEADBEEF}} || v2 !== {2{32'hDEADBEEF}}) begin
            errors++; $display("FAIL tag0_bypass got busy=%b v1=%h expected 0000 deadbeef", {busy1, busy2}, v1);
        end
        cycle();
        checks++;
        if (busy_cnt !== 6'd0 || busy1 !== 2'b00 || v1[31:0] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL tag0_after got cnt=%0d busy=%b v=%h expected 0 00 deadbeef", busy_cnt, busy1, v1[31:0]);
        end
    endtask

    task automatic test_stale_commit();
        read_all(5'd4);
        do_issue(5'd4, 4'd2); cycle();
        do_issue(5'd4, 4'd7); cycle();
        do_commit(5'd4, 4'd2, 32'h11); #1;
        checks++;
        if (busy1 !== 2'b11 || v1[31:0] === 32'h11) begin
            errors++; $display("FAIL stale_no_bypass got busy=%b v=%h expected 11, no forward", busy1, v1[31:0]);
        end
        cycle();
        checks++;
        if (v1[31:0] !== 32'h11 || busy2 !== 2'b11 || q2[3:0] !== 4'd7) begin
            errors++; $display("FAIL stale_state got v=%h busy=%b q=%0d expected 11 11 7", v1[31:0], busy2, q2[3:0]);
        end
        checks++;
        if (busy_cnt !== 6'd1) begin
            errors++; $display("FAIL stale_cnt got %0d expected 1", busy_cnt);
        end
        do_commit(5'd4, 4'd7, 32'h12); cycle();
        checks++;
        if (busy_cnt !== 6'd0 || busy1 !== 2'b00 || v1[31:0] !== 32'h12) begin
            errors++; $display("FAIL stale_retire got cnt=%0d busy=%b v=%h expected 0 00 12", busy_cnt, busy1, v1[31:0]);
        end
    endtask

    task automatic test_same_cycle();
        read_all(5'd6);
        do_issue(5'd6, 4'd5); do_commit(5'd6, 4'd1, 32'h22); cycle();
        checks++;
        if (v1[63:32] !== 32'h22 || busy1 !== 2'b11 || q1[7:4] !== 4'd5 || busy_cnt !== 6'd1) begin
            errors++; $display("FAIL same_idle got v=%h busy=%b q=%0d cnt=%0d expected 22 11 5 1",
                               v1[63:32], busy1, q1[7:4], busy_cnt);
        end
        // Already busy: retire tag 5 while re-renaming to 8 nets zero.
        do_issue(5'd6, 4'd8); do_commit(5'd6, 4'd5, 32'h23); cycle();
        checks++;
        if (v2[31:0] !== 32'h23 || busy2 !== 2'b11 || q2[3:0] !== 4'd8 || busy_cnt !== 6'd1) begin
            errors++; $display("FAIL same_busy got v=%h busy=%b q=%0d cnt=%0d expected 23 11 8 1",
                               v2[31:0], busy2, q2[3:0], busy_cnt);
        end
        do_commit(5'd6, 4'd8, 32'h24); cycle();
        checks++;
        if (busy_cnt !== 6'd0) begin
            errors++; $display("FAIL same_retire_cnt got %0d expected 0", busy_cnt);
        end
    endtask

    task automatic test_flush();
        do_issue(5'd1, 4'd1); cycle();
        do_issue(5'd2, 4'd2); cycle();
        do_issue(5'd9, 4'd3); cycle();
        checks++;
        if (busy_cnt !== 6'd3) begin
            errors++; $display("FAIL flush_pre_cnt got %0d expected 3", busy_cnt);
        end
        flush = 1; do_commit(5'd2, 4'd2, 32'h33); do_issue(5'd10, 4'd4); cycle();
        rs1 = {5'd2, 5'd1}; rs2 = {5'd10, 5'd9}; #1;
        checks++;
        if ({busy1, busy2} !== 4'b0000) begin
            errors++; $display("FAIL flush_busy got %b expected 0000", {busy1, busy2});
        end
        checks++;
        if (v1[63:32] !== 32'h33) begin
            errors++; $display("FAIL flush_commit_v got %h expected 33", v1[63:32]);
        end
        checks++;
        if (busy_cnt !== 6'd0) begin
            errors++; $display("FAIL flush_cnt got %0d expected 0", busy_cnt);
        end
    endtask

    task automatic test_rdy_low();
        rdy = 0; do_issue(5'd7, 4'd1); do_commit(5'd3, 4'd0, 32'h55);
        rs1 = {5'd3, 5'd7}; #1;
        cycle();
        rs1 = {5'd3, 5'd7}; #1;
        checks++;
        if (busy1 !== 2'b00 || v1[63:32] !== 32'hDEADBEEF || busy_cnt !== 6'd0) begin
            errors++; $display("FAIL rdy_hold got busy=%b v3=%h cnt=%0d expected 00 deadbeef 0",
                               busy1, v1[63:32], busy_cnt);
        end
    endtask

    task automatic test_x0();
        read_all(5'd0);
        do_issue(5'd0, 4'd3); do_commit(5'd0, 4'd0, 32'h99); #1;
        checks++;
        if ({v1, v2} !== '0 || {busy1, busy2} !== '0) begin
            errors++; $display("FAIL x0_comb got v=%h busy=%b expected 0", {v1, v2}, {busy1, busy2});
        end
        cycle();
        checks++;
        if ({v1, v2} !== '0 || {busy1, busy2} !== '0 || busy_cnt !== 6'd0) begin
            errors++; $display("FAIL x0_state got v=%h busy=%b cnt=%0d expected 0", {v1, v2}, {busy1, busy2}, busy_cnt);
        end
    endtask

    task automatic test_reset_mid();
        do_issue(5'd5, 4'd1); cycle();
        rst_n = 0; cycle();
        rst_n = 1;
        rs1 = {5'd3, 5'd5}; #1;
        checks++;
        if (busy1 !== 2'b00 || v1 !== '0 || busy_cnt !== 6'd0) begin
            errors++; $display("FAIL reset_mid got busy=%b v=%h cnt=%0d expected 0", busy1, v1, busy_cnt);
        end
    endtask

    initial begin
        idle();
        rst_n = 0;
        rs1 = '0; rs2 = '0;
        test_reset();
        test_tag0();
        test_stale_commit();
        test_same_cycle();
        test_flush();
        test_rdy_low();
        test_x0();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
